// File: rtl/grf_wport_arbiter_pkg.sv
// Shared GRF write-port definitions.
// Holds the aux write-queue entry bundle.
package grf_wport_arbiter_pkg;

  localparam int GRF_AW = 5;
  localparam int WORD   = 32;

  localparam logic [GRF_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [GRF_AW-1:0] a3;
    logic [WORD-1:0]   wd;
    logic [WORD-1:0]   pc;
  } aux_ent_t;

endpackage

// File: rtl/grf_wq_fifo.sv
// Aux write queue with per-entry valid bits,
// kill-by-address and two pending-read matches.
module grf_wq_fifo
  import grf_wport_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  aux_ent_t          i_push_ent,
  input  logic              i_pop,
  input  logic              i_kill,
  input  logic [GRF_AW-1:0] i_kill_a3,
  input  logic [GRF_AW-1:0] i_rd_a1,
  input  logic [GRF_AW-1:0] i_rd_a2,
  output aux_ent_t          o_head,
  output logic [CW-1:0]     o_count,
  output logic              o_pend_a1,
  output logic              o_pend_a2
);

  aux_ent_t      r_ent [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  assign o_head  = r_ent[r_rd];
  assign o_count = r_count;

  always_comb begin
    o_pend_a1 = 1'b0;
    o_pend_a2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ent[i].valid && r_ent[i].a3 == i_rd_a1)
        o_pend_a1 = 1'b1;
      if (r_ent[i].valid && r_ent[i].a3 == i_rd_a2)
        o_pend_a2 = 1'b1;
    end
    if (i_rd_a1 == REG_ZERO) o_pend_a1 = 1'b0;
    if (i_rd_a2 == REG_ZERO) o_pend_a2 = 1'b0;
  end

  // Push is applied last so a same-cycle push is never killed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_kill && r_ent[i].a3 == i_kill_a3)
          r_ent[i].valid <= 1'b0;
      if (i_pop) begin
        r_ent[r_rd].valid <= 1'b0;
        r_rd              <= r_rd + 1'b1;
      end
      if (i_push) begin
        r_ent[r_wr] <= i_push_ent;
        r_wr        <= r_wr + 1'b1;
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

endmodule

// File: rtl/grf_wport_arbiter.sv
// GRF write-port arbiter: pipeline writes win,
// queued aux writes drain into idle slots.
module grf_wport_arbiter
  import grf_wport_arbiter_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  int MAX_WAIT = 8,
  localparam int CW       = $clog2(DEPTH) + 1,
  localparam int WW       = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRF_AW-1:0] w_a3,
  input  logic [WORD-1:0]   w_wd,
  input  logic [WORD-1:0]   w_pc,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [GRF_AW-1:0] aux_a3,
  input  logic [WORD-1:0]   aux_wd,
  input  logic [WORD-1:0]   aux_pc,
  output logic [GRF_AW-1:0] grf_a3,
  output logic [WORD-1:0]   grf_wd,
  output logic [WORD-1:0]   grf_pc,
  input  logic [GRF_AW-1:0] rd_a1,
  input  logic [GRF_AW-1:0] rd_a2,
  output logic              pend_a1,
  output logic              pend_a2,
  output logic              force_stall,
  output logic [CW-1:0]     fifo_count
);

  aux_ent_t      w_head;
  aux_ent_t      w_push_ent;
  logic [CW-1:0] w_count;
  logic          w_busy;
  logic          w_pop;
  logic          w_push;
  logic          w_head_kill;
  logic [WW-1:0] r_wait;

  assign w_busy      = (w_a3 != REG_ZERO);
  // An invalid head retires even while the pipeline owns the port.
  assign w_pop       = (w_count != '0) && (!w_busy || !w_head.valid);
  assign aux_ready   = (w_count < CW'(DEPTH)) || w_pop;
  assign w_push      = aux_valid && aux_ready && (aux_a3 != REG_ZERO);
  assign w_head_kill = w_busy && w_head.valid && (w_head.a3 == w_a3);
  assign w_push_ent  = '{valid: 1'b1, a3: aux_a3, wd: aux_wd, pc: aux_pc};
  assign fifo_count  = w_count;
  assign force_stall = (r_wait == WW'(MAX_WAIT));

  grf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_ent (w_push_ent),
    .i_pop      (w_pop),
    .i_kill     (w_busy),
    .i_kill_a3  (w_a3),
    .i_rd_a1    (rd_a1),
    .i_rd_a2    (rd_a2),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_pend_a1  (pend_a1),
    .o_pend_a2  (pend_a2)
  );

  always_comb begin
    grf_a3 = REG_ZERO;
    grf_wd = '0;
    grf_pc = '0;
    if (w_busy) begin
      grf_a3 = w_a3;
      grf_wd = w_wd;
      grf_pc = w_pc;
    end else if (w_head.valid) begin
      grf_a3 = w_head.a3;
      grf_wd = w_head.wd;
      grf_pc = w_head.pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      r_wait <= '0;
    else if (!w_head.valid || w_pop || w_head_kill)
      r_wait <= '0;
    else if (w_busy && !force_stall)
      r_wait <= r_wait + 1'b1;
  end

endmodule
